// File: rtl/aux_bus_periph.sv
// rtl/aux_bus_periph.sv - aux-bus slave: windowed local RAM plus host mailbox FIFOs
//
// aux_bus_fifo   : circular FIFO used for both mailbox directions.
//   en_i gates all updates; a push is taken only when the FIFO is not full,
//   and a pop only when it is not empty. Both tests use the start-of-cycle count.
//
// aux_bus_periph : aux-bus slave.
//   clk_i, reset_n_i, clk_en_i              clock, async active-low reset, clock enable
//   aux_adr_i, aux_dat_i, aux_we_i, aux_re_i aux bus from the core
//   aux_dat_o, aux_dat_oe_o                  registered read data and pad drive enable
//   host_in_*                                host-to-core stream (feeds the in-FIFO)
//   host_out_*                               core-to-host stream (drains the out-FIFO)
//   irq_o                                    in-FIFO non-empty or any sticky error bit set

module aux_bus_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          en_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count == FULL_COUNT);
    assign empty_o = (count == '0);
    assign do_push = en_i & push_i & ~full_o;
    assign do_pop  = en_i & pop_i & ~empty_o;
    assign head_o  = mem[rd_ptr];
    assign count_o = count;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // Storage is not reset; only the pointers and count define contents.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_dat_i;
    end
endmodule

module aux_bus_periph #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = 16'h0000,
    parameter int                    RAM_AW     = 10,
    parameter logic [ADDR_WIDTH-1:0] MBX_BASE   = 16'hFF00,
    parameter int                    FIFO_AW    = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  clk_en_i,
    input  logic [ADDR_WIDTH-1:0] aux_adr_i,
    input  logic [DATA_WIDTH-1:0] aux_dat_i,
    output logic [DATA_WIDTH-1:0] aux_dat_o,
    output logic                  aux_dat_oe_o,
    input  logic                  aux_we_i,
    input  logic                  aux_re_i,
    input  logic [DATA_WIDTH-1:0] host_in_dat_i,
    input  logic                  host_in_valid_i,
    output logic                  host_in_ready_o,
    output logic [DATA_WIDTH-1:0] host_out_dat_o,
    output logic                  host_out_valid_o,
    input  logic                  host_out_ready_i,
    output logic                  irq_o
);
    logic [DATA_WIDTH-1:0] ram [1 << RAM_AW];

    logic                  ram_hit;
    logic                  mbx_hit;
    logic                  we_q;
    logic                  re_q;
    logic                  we_edge;
    logic                  re_edge;
    logic                  rd_hit_q;
    logic                  mbx_wr_data;
    logic                  mbx_wr_stat;
    logic                  mbx_rd_data;

    logic [DATA_WIDTH-1:0] in_head;
    logic [DATA_WIDTH-1:0] out_head;
    logic [FIFO_AW:0]      in_count;
    logic [FIFO_AW:0]      out_count;
    logic                  in_full;
    logic                  in_empty;
    logic                  out_full;
    logic                  out_empty;

    logic                  oovf;
    logic                  iunf;
    logic                  iovf;
    logic                  set_oovf;
    logic                  set_iunf;
    logic                  set_iovf;
    logic [2:0]            clr;
    logic [7:0]            status;
    logic [DATA_WIDTH-1:0] rd_data;

    assign ram_hit = (aux_adr_i[ADDR_WIDTH-1:RAM_AW] == RAM_BASE[ADDR_WIDTH-1:RAM_AW]);
    assign mbx_hit = (aux_adr_i[ADDR_WIDTH-1:2] == MBX_BASE[ADDR_WIDTH-1:2]);

    // One action per rising strobe edge, sampled only on enabled clocks.
    assign we_edge = clk_en_i & aux_we_i & ~we_q;
    assign re_edge = clk_en_i & aux_re_i & ~re_q;

    assign mbx_wr_data = we_edge & mbx_hit & (aux_adr_i[1:0] == 2'd0);
    assign mbx_wr_stat = we_edge & mbx_hit & (aux_adr_i[1:0] == 2'd1);
    assign mbx_rd_data = re_edge & mbx_hit & (aux_adr_i[1:0] == 2'd0);

    aux_bus_fifo #(.DW(DATA_WIDTH), .AW(FIFO_AW)) u_in_fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .en_i       (clk_en_i),
        .push_i     (host_in_valid_i),
        .push_dat_i (host_in_dat_i),
        .pop_i      (mbx_rd_data),
        .head_o     (in_head),
        .count_o    (in_count),
        .full_o     (in_full),
        .empty_o    (in_empty)
    );

    aux_bus_fifo #(.DW(DATA_WIDTH), .AW(FIFO_AW)) u_out_fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .en_i       (clk_en_i),
        .push_i     (mbx_wr_data),
        .push_dat_i (aux_dat_i),
        .pop_i      (host_out_ready_i),
        .head_o     (out_head),
        .count_o    (out_count),
        .full_o     (out_full),
        .empty_o    (out_empty)
    );

    assign host_in_ready_o  = ~in_full;
    assign host_out_valid_o = ~out_empty;
    assign host_out_dat_o   = out_empty ? '0 : out_head;

    assign set_oovf = mbx_wr_data & out_full;
    assign set_iunf = mbx_rd_data & in_empty;
    assign set_iovf = host_in_valid_i & in_full;
    assign clr      = mbx_wr_stat ? aux_dat_i[6:4] : 3'b000;

    assign status = {1'b0, iovf, iunf, oovf, out_full, out_empty, in_full, in_empty};
    assign irq_o  = ~in_empty | oovf | iunf | iovf;

    always_comb begin
        rd_data = '0;
        if (ram_hit) begin
            rd_data = ram[aux_adr_i[RAM_AW-1:0]];
        end else if (mbx_hit) begin
            case (aux_adr_i[1:0])
                2'd0:    rd_data = in_empty ? '0 : in_head;
                2'd1:    rd_data = DATA_WIDTH'(status);
                2'd2:    rd_data = DATA_WIDTH'(in_count);
                default: rd_data = DATA_WIDTH'(out_count);
            endcase
        end
    end

    // Strobe history resets high so a strobe already asserted when reset
    // releases is treated as in progress rather than as a new edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            we_q      <= 1'b1;
            re_q      <= 1'b1;
            rd_hit_q  <= 1'b0;
            aux_dat_o <= '0;
            oovf      <= 1'b0;
            iunf      <= 1'b0;
            iovf      <= 1'b0;
        end else if (clk_en_i) begin
            we_q <= aux_we_i;
            re_q <= aux_re_i;
            if (re_edge) begin
                aux_dat_o <= rd_data;
                rd_hit_q  <= ram_hit | mbx_hit;
            end
            // A same-cycle set wins over a write-one-to-clear.
            oovf <= set_oovf | (oovf & ~clr[0]);
            iunf <= set_iunf | (iunf & ~clr[1]);
            iovf <= set_iovf | (iovf & ~clr[2]);
        end
    end

    assign aux_dat_oe_o = aux_re_i & rd_hit_q;

    always_ff @(posedge clk_i) begin
        if (we_edge && ram_hit) ram[aux_adr_i[RAM_AW-1:0]] <= aux_dat_i;
    end
endmodule

// File: tb/tb_aux_bus_periph.sv
// tb/tb_aux_bus_periph.sv - self-checking bench for aux_bus_periph

module tb_aux_bus_periph;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic [15:0] adr;
    logic [7:0]  wdat;
    logic [7:0]  rdat;
    logic        oe;
    logic        we;
    logic        re;
    logic [7:0]  hin_dat;
    logic        hin_valid;
    logic        hin_ready;
    logic [7:0]  hout_dat;
    logic        hout_valid;
    logic        hout_ready;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    aux_bus_periph dut (
        .clk_i            (clk),
        .reset_n_i        (rst_n),
        .clk_en_i         (clk_en),
        .aux_adr_i        (adr),
        .aux_dat_i        (wdat),
        .aux_dat_o        (rdat),
        .aux_dat_oe_o     (oe),
        .aux_we_i         (we),
        .aux_re_i         (re),
        .host_in_dat_i    (hin_dat),
        .host_in_valid_i  (hin_valid),
        .host_in_ready_o  (hin_ready),
        .host_out_dat_o   (hout_dat),
        .host_out_valid_o (hout_valid),
        .host_out_ready_i (hout_ready),
        .irq_o            (irq)
    );

    // Reference model: queues for the FIFOs, flags for sticky bits.
    logic [7:0] in_q[$];
    logic [7:0] out_q[$];
    logic [7:0] m_ram [1024];
    bit         m_oovf, m_iunf, m_iovf;
    bit         m_we_prev, m_re_prev, m_rd_hit;
    logic [7:0] m_dat;

    function automatic logic [7:0] m_status();
        return {1'b0, m_iovf, m_iunf, m_oovf, out_q.size() == 16, out_q.size() == 0,
                in_q.size() == 16, in_q.size() == 0};
    endfunction

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        m_oovf = 0; m_iunf = 0; m_iovf = 0;
        m_we_prev = 1; m_re_prev = 1;
        m_rd_hit = 0;
        m_dat = 8'h00;
    endtask

    task automatic model_step();
        int ni, no;
        bit we_e, re_e, is_ram, is_mbx, s_oovf, s_iunf, s_iovf;
        logic [2:0] clr;
        logic [7:0] rd;
        if (!rst_n || !clk_en) return;
        ni = in_q.size();
        no = out_q.size();
        we_e = we && !m_we_prev;
        re_e = re && !m_re_prev;
        is_ram = adr < 16'h0400;
        is_mbx = adr >= 16'hFF00 && adr <= 16'hFF03;
        clr = 3'b000;
        s_oovf = 0; s_iunf = 0;
        s_iovf = hin_valid && ni == 16;
        if (re_e) begin
            rd = 8'h00;
            if (is_ram) rd = m_ram[adr[9:0]];
            else if (is_mbx) begin
                case (adr[1:0])
                    2'd0: if (ni == 0) s_iunf = 1; else rd = in_q.pop_front();
                    2'd1: rd = m_status();
                    2'd2: rd = 8'(ni);
                    default: rd = 8'(no);
                endcase
            end
            m_dat = rd;
            m_rd_hit = is_ram || is_mbx;
        end
        if (no > 0 && hout_ready) void'(out_q.pop_front());
        if (hin_valid && ni < 16) in_q.push_back(hin_dat);
        if (we_e) begin
            if (is_ram) m_ram[adr[9:0]] = wdat;
            else if (is_mbx && adr[1:0] == 2'd0) begin
                if (no == 16) s_oovf = 1; else out_q.push_back(wdat);
            end else if (is_mbx && adr[1:0] == 2'd1) clr = wdat[6:4];
        end
        m_oovf = s_oovf || (m_oovf && !clr[0]);
        m_iunf = s_iunf || (m_iunf && !clr[1]);
        m_iovf = s_iovf || (m_iovf && !clr[2]);
        m_we_prev = we;
        m_re_prev = re;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_in_ready"}, hin_ready, in_q.size() < 16);
        chk({tag, "_out_valid"}, hout_valid, out_q.size() > 0);
        chk({tag, "_out_dat"}, hout_dat, out_q.size() > 0 ? out_q[0] : 8'h00);
        chk({tag, "_irq"}, irq, in_q.size() > 0 || m_oovf || m_iunf || m_iovf);
        chk({tag, "_oe"}, oe, re && m_rd_hit);
        chk({tag, "_rdat"}, rdat, m_dat);
    endtask

    task automatic aux_wr(input logic [15:0] a, input logic [7:0] d);
        adr = a; wdat = d; we = 1;
        cycle();
        we = 0;
        cycle();
    endtask

    task automatic aux_rd(input logic [15:0] a, output logic [7:0] d, output logic o);
        adr = a; re = 1;
        cycle();
        d = rdat;
        o = oe;
        re = 0;
        cycle();
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic o;
        aux_rd(a, d, o);
        chk(name, d, exp);
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp_dat;
        bit          exp_oe;
        string       name;
    } vec_t;

    vec_t vecs[13];
    logic [15:0] addr_pool[14] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                   16'h0005, 16'h0006, 16'h0007, 16'hFF00, 16'hFF01,
                                   16'hFF02, 16'hFF03, 16'h0400, 16'h1234};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic o;

        vecs[0]  = '{1, 16'h0003, 8'hA5, 8'h00, 0, "ram_w3"};
        vecs[1]  = '{1, 16'h03FF, 8'h3C, 8'h00, 0, "ram_w3ff"};
        vecs[2]  = '{0, 16'h0003, 8'h00, 8'hA5, 1, "ram_r3"};
        vecs[3]  = '{0, 16'h03FF, 8'h00, 8'h3C, 1, "ram_r3ff"};
        vecs[4]  = '{0, 16'h0400, 8'h00, 8'h00, 0, "miss_r400"};
        vecs[5]  = '{1, 16'h0000, 8'h5A, 8'h00, 0, "ram_w0"};
        vecs[6]  = '{1, 16'h0400, 8'h77, 8'h00, 0, "miss_w400"};
        vecs[7]  = '{0, 16'h0000, 8'h00, 8'h5A, 1, "ram_r0_noalias"};
        vecs[8]  = '{0, 16'hFF03, 8'h00, 8'h00, 1, "mbx_outcnt0"};
        vecs[9]  = '{0, 16'hFF01, 8'h00, 8'h05, 1, "mbx_status_rst"};
        vecs[10] = '{1, 16'hFF02, 8'h09, 8'h00, 0, "mbx_w_ro"};
        vecs[11] = '{0, 16'hFF02, 8'h00, 8'h00, 1, "mbx_incnt0"};
        vecs[12] = '{0, 16'h1234, 8'h00, 8'h00, 0, "miss_r1234"};

        for (int i = 0; i < 1024; i++) m_ram[i] = 8'h00;

        rst_n = 0; clk_en = 1; adr = 0; wdat = 0; we = 0; re = 0;
        hin_dat = 0; hin_valid = 0; hout_ready = 0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_rdat", rdat, 8'h00);
        chk("rst_oe", oe, 1'b0);
        chk("rst_in_ready", hin_ready, 1'b1);
        chk("rst_out_valid", hout_valid, 1'b0);
        chk("rst_out_dat", hout_dat, 8'h00);
        chk("rst_irq", irq, 1'b0);
        rst_n = 1;
        cycle();

        // Decode and RAM round trip table
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) aux_wr(vecs[i].addr, vecs[i].data);
            else begin
                aux_rd(vecs[i].addr, d, o);
                chk({vecs[i].name, "_dat"}, d, vecs[i].exp_dat);
                chk({vecs[i].name, "_oe"}, o, vecs[i].exp_oe);
            end
        end

        // Out-FIFO stream
        aux_wr(16'hFF00, 8'h11);
        aux_wr(16'hFF00, 8'h22);
        aux_wr(16'hFF00, 8'h33);
        rd_chk("out_cnt3", 16'hFF03, 8'h03);
        hout_ready = 1;
        chk("out_head0", hout_dat, 8'h11);
        chk("out_valid0", hout_valid, 1'b1);
        cycle();
        chk("out_head1", hout_dat, 8'h22);
        cycle();
        chk("out_head2", hout_dat, 8'h33);
        cycle();
        chk("out_drained", hout_valid, 1'b0);
        hout_ready = 0;

        // In-FIFO fill and overflow; one out entry kept so out_empty is clear
        aux_wr(16'hFF00, 8'h99);
        hin_valid = 1;
        for (int i = 0; i < 16; i++) begin
            hin_dat = 8'(i);
            cycle();
        end
        hin_valid = 0;
        chk("in_full_ready", hin_ready, 1'b0);
        rd_chk("status_full", 16'hFF01, 8'h02);
        hin_valid = 1; hin_dat = 8'hEE;
        cycle();
        hin_valid = 0;
        rd_chk("status_iovf", 16'hFF01, 8'h42);
        chk("irq_iovf", irq, 1'b1);
        for (int i = 0; i < 16; i++) rd_chk($sformatf("in_pop%0d", i), 16'hFF00, 8'(i));
        rd_chk("in_underflow_dat", 16'hFF00, 8'h00);
        rd_chk("status_iunf", 16'hFF01, 8'h61);

        // Out-FIFO overflow, drain, then W1C of all sticky bits
        for (int i = 0; i < 16; i++) aux_wr(16'hFF00, 8'hC0 + 8'(i));
        rd_chk("out_cnt_full", 16'hFF03, 8'h10);
        hout_ready = 1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), hout_dat, i == 0 ? 8'h99 : 8'hC0 + 8'(i - 1));
            cycle();
        end
        hout_ready = 0;
        rd_chk("status_all_sticky", 16'hFF01, 8'h75);
        aux_wr(16'hFF01, 8'h70);
        rd_chk("status_cleared", 16'hFF01, 8'h05);
        chk("irq_cleared", irq, 1'b0);

        // Long read strobe acts once
        hin_valid = 1; hin_dat = 8'hA1;
        cycle();
        hin_dat = 8'hA2;
        cycle();
        hin_valid = 0;
        adr = 16'hFF00; re = 1;
        for (int i = 0; i < 6; i++) cycle();
        chk("long_re_dat", rdat, 8'hA1);
        re = 0;
        cycle();
        rd_chk("long_re_cnt", 16'hFF02, 8'h01);

        // Clock enable low freezes everything, including strobe edges
        clk_en = 0; hin_valid = 1; hin_dat = 8'h77;
        adr = 16'hFF00; wdat = 8'h55; we = 1;
        cycle(); cycle();
        we = 0;
        cycle();
        hin_valid = 0; clk_en = 1;
        cycle();
        rd_chk("clken_incnt", 16'hFF02, 8'h01);
        rd_chk("clken_outcnt", 16'hFF03, 8'h00);

        // Asynchronous reset with both FIFOs holding 5 entries and a write in progress
        hin_valid = 1;
        for (int i = 0; i < 4; i++) begin
            hin_dat = 8'hB0 + 8'(i);
            cycle();
        end
        hin_valid = 0;
        for (int i = 0; i < 5; i++) aux_wr(16'hFF00, 8'hD0 + 8'(i));
        rd_chk("pre_rst_incnt", 16'hFF02, 8'h05);
        adr = 16'hFF00; wdat = 8'hAB; we = 1;
        rst_n = 0;
        model_reset();
        #2;
        chk("arst_in_ready", hin_ready, 1'b1);
        chk("arst_out_valid", hout_valid, 1'b0);
        chk("arst_irq", irq, 1'b0);
        cycle(); cycle();
        rst_n = 1;
        cycle(); cycle(); cycle();
        we = 0;
        cycle();
        rd_chk("post_rst_outcnt", 16'hFF03, 8'h00);
        rd_chk("post_rst_incnt", 16'hFF02, 8'h00);
        rd_chk("post_rst_status", 16'hFF01, 8'h05);

        // Randomised traffic against the model
        for (int i = 0; i < 8; i++) aux_wr(16'(i), 8'($urandom));
        for (int c = 0; c < 1500; c++) begin
            clk_en = ($urandom_range(7) != 0);
            hin_valid = 1'($urandom_range(1));
            hin_dat = 8'($urandom);
            hout_ready = ($urandom_range(2) == 0);
            wdat = 8'($urandom);
            if (!we && !re) begin
                if ($urandom_range(2) == 0) begin
                    adr = addr_pool[$urandom_range(13)];
                    if ($urandom_range(1) == 1) we = 1; else re = 1;
                end
            end else if ($urandom_range(2) == 0) begin
                we = 0; re = 0;
            end
            cycle();
            check_model("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aux_bus_periph.md
Name: aux_bus_periph

Overview:
- Parametrised aux-bus slave for the risc16f84 aux bus.
- Replaces the bare aux-bus test RAM with a decoded peripheral: a windowed local RAM plus a mailbox register block. The mailbox is two FIFOs bridging the core to a host-side valid/ready stream.
- Sits on the core's aux_adr/aux_dat/aux_we/aux_re bus. The tri-state pad is resolved outside this block using aux_dat_oe_o.

Parameters:
- DATA_WIDTH, 8, aux data width.
- ADDR_WIDTH, 16, aux address width.
- RAM_BASE, 16'h0000, base address of RAM window. Must be aligned to 2^RAM_AW.
- RAM_AW, 10, log2 of RAM window depth in words.
- MBX_BASE, 16'hFF00, base of the 4-register mailbox block. Must be 4-aligned and must not overlap the RAM window.
- FIFO_AW, 4, log2 depth of each FIFO. Depth = 2^FIFO_AW.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- clk_en_i  in  1  clock enable; gates all state updates, including edge detectors
- aux_adr_i  in  ADDR_WIDTH  aux address
- aux_dat_i  in  DATA_WIDTH  aux write data
- aux_dat_o  out  DATA_WIDTH  registered aux read data
- aux_dat_oe_o  out  1  drive enable for aux_dat_o
- aux_we_i  in  1  aux write strobe, active high
- aux_re_i  in  1  aux read strobe, active high
- host_in_dat_i  in  DATA_WIDTH  host-to-core data
- host_in_valid_i  in  1  host-to-core valid
- host_in_ready_o  out  1  host-to-core ready; equals in-FIFO not full
- host_out_dat_o  out  DATA_WIDTH  core-to-host data; equals out-FIFO head
- host_out_valid_o  out  1  core-to-host valid; equals out-FIFO not empty
- host_out_ready_i  in  1  core-to-host ready
- irq_o  out  1  level interrupt: in-FIFO non-empty OR any sticky error bit set

Behaviour:
- Reset values:
  - aux_dat_o = 0, aux_dat_oe_o = 0, both FIFOs empty, sticky bits = 0, irq_o = 0.
  - host_in_ready_o = 1, host_out_valid_o = 0, host_out_dat_o = 0.
  - RAM contents are not reset.
- Reset is asynchronous and takes effect mid-transfer: pointers and counts clear, and any strobe in progress is discarded.
- Decode:
  - RAM hit: aux_adr_i[ADDR_WIDTH-1:RAM_AW] == RAM_BASE[ADDR_WIDTH-1:RAM_AW].
  - MBX hit: aux_adr_i[ADDR_WIDTH-1:2] == MBX_BASE[ADDR_WIDTH-1:2].
  - Miss: writes are ignored, reads give oe = 0 and data = 0.
- Strobes are edge-detected on enabled clocks. Exactly one write or one read action happens per rising edge of aux_we_i or aux_re_i. A strobe held high for many cycles acts once.
- Write: performed on the clk_en cycle where aux_we_i is high and its registered copy is low.
- Read: on the rising edge of aux_re_i, aux_dat_o is loaded with the addressed data (1-cycle latency) and held until the next read. aux_dat_oe_o = aux_re_i AND (registered hit of the last read).
- Mailbox map:
  - +0 write: push aux_dat_i into the out-FIFO. If the out-FIFO is full, the data is dropped and OOVF is set.
  - +0 read: pop the in-FIFO and return its head. If the in-FIFO is empty, return 0, leave pointers unchanged, and set IUNF.
  - +1 STATUS (RW1C on bits 4-6):
    - b0 in_empty, b1 in_full, b2 out_empty, b3 out_full
    - b4 OOVF, b5 IUNF, b6 IOVF
    - b7 = 0
  - +2 read-only: in-FIFO count, 0..2^FIFO_AW.
  - +3 read-only: out-FIFO count, 0..2^FIFO_AW.
  - Writes to +2 and +3 are ignored.
- Host side:
  - In-FIFO push occurs when host_in_valid_i AND host_in_ready_o.
  - IOVF is set when host_in_valid_i is high while the in-FIFO is full. Data is held by the handshake, not lost; IOVF is diagnostic only.
  - Out-FIFO pop occurs when host_out_valid_o AND host_out_ready_i.
- FIFOs:
  - Circular buffers with FIFO_AW-bit pointers and a (FIFO_AW+1)-bit count. Pointers wrap naturally modulo depth.
  - Full and empty are evaluated from the start-of-cycle count.
  - Simultaneous push and pop on a non-empty, non-full FIFO: both occur and the count is unchanged.
  - When full, a push is rejected even if a pop happens in the same cycle.
  - When empty, a pop is rejected even if a push happens in the same cycle.
- Sticky bits:
  - Setting takes priority over a same-cycle W1C clear.
  - clk_en_i = 0 freezes everything, including the sticky bits.

Test Plan:
- RAM round trip: write 0xA5 to 0x0003 and 0x3C to 0x03FF; read both back -> aux_dat_o = 0xA5 then 0x3C, oe high during re. Read 0x0400 (miss) -> oe = 0.
- Out-FIFO stream: write 0x11, 0x22, 0x33 to MBX+0 with host_out_ready_i = 0. Then:
  - read MBX+3 -> 0x03;
  - raise host_out_ready_i -> host_out_dat_o sequence 0x11, 0x22, 0x33, then valid = 0.
- In-FIFO fill/overflow: host pushes 16 bytes 0x00..0x0F. Then:
  - host_in_ready_o = 0, STATUS = 0x02;
  - hold valid one more cycle -> IOVF set (STATUS = 0x42), irq_o = 1;
  - 16 reads of MBX+0 return 0x00..0x0F;
  - a 17th read returns 0 with IUNF set.
- Sticky clear: with OOVF/IUNF/IOVF set, write 0x70 to MBX+1 -> STATUS = 0x05, irq_o = 0.
- Single action per long strobe: aux_re_i held high for 6 cycles on MBX+0 with 2 entries -> MBX+2 reads 0x01 afterwards.
- Reset mid-operation: deassert reset_n_i with both FIFOs holding 5 entries while aux_we_i is high -> counts 0, STATUS = 0x05, host_in_ready_o = 1. Releasing reset with aux_we_i still high produces no write.
